sideband_rx_deserializer: RTL and testbench

SIDEBAND_RX_DESERIALIZER -- requirements
Module: sideband_rx_deserializer

---
 rtl/sideband_rx_deserializer.sv | 158 +++++++++++++++
 tb/tb_sideband_rx_deserializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sideband_rx_deserializer.sv
// Sideband receiver: oversamples the gated RXCKSB/RXDATASB pair on pll_clk and
// assembles LSB-first packets of DATA_W bits into a one-deep output register.
module sideband_rx_deserializer #(
   parameter int DATA_W       = 64,
   parameter int GAP_MIN_CYC  = 64,
   parameter int EDGE_TIMEOUT = 4
) (
   input  logic              pll_clk,
   input  logic              rst,
   input  logic              RXCKSB,
   input  logic              RXDATASB,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              busy,
   output logic              trunc_err,
   output logic              gap_err,
   output logic              ovf_err
);

   localparam int BC_W = $clog2(DATA_W + 1);
   localparam int GC_W = $clog2(GAP_MIN_CYC + 1);
   localparam int TC_W = $clog2(EDGE_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RECV, GAP} state_t;

   state_t            state_q, state_d;
   logic              ck_q, ck_d, ck_prev_q, ck_prev_d, d_q, d_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [TC_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              trunc_err_q, trunc_err_d;
   logic              gap_err_q, gap_err_d;
   logic              ovf_err_q, ovf_err_d;
   logic              rise, hs;

   // Receive FSM; the shift register simply shifts on every edge because a full
   // packet always overwrites all DATA_W bits before it is handed off.
   always_comb begin
      ck_d        = RXCKSB;
      d_d         = RXDATASB;
      ck_prev_d   = ck_q;
      rise        = ck_q & ~ck_prev_q;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      sr_d        = rise ? {d_q, sr_q[DATA_W-1:1]} : sr_q;
      done_d      = 1'b0;
      trunc_err_d = 1'b0;
      gap_err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               bit_cnt_d = BC_W'(1);
               tmo_cnt_d = '0;
               state_d   = RECV;
            end
         end
         RECV: begin
            if (rise) begin
               tmo_cnt_d = '0;
               if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                  done_d    = 1'b1;
                  bit_cnt_d = '0;
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
               end
            end else if (tmo_cnt_q == TC_W'(EDGE_TIMEOUT - 1)) begin
               trunc_err_d = 1'b1;
               bit_cnt_d   = '0;
               tmo_cnt_d   = '0;
               state_d     = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TC_W'(1);
            end
         end
         GAP: begin
            if (rise) begin
               gap_err_d = (gap_cnt_q < GC_W'(GAP_MIN_CYC));
               bit_cnt_d = BC_W'(1);
               tmo_cnt_d = '0;
               state_d   = RECV;
            end else if (gap_cnt_q >= GC_W'(GAP_MIN_CYC)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output holding register: a completed word loads only if the slot is free
   // or being drained this cycle; otherwise it is dropped and flagged.
   always_comb begin
      hs           = data_valid_q & data_ready;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q & ~hs;
      ovf_err_d    = 1'b0;
      if (done_q) begin
         if (!data_valid_q || hs) begin
            data_out_d   = sr_q;
            data_valid_d = 1'b1;
         end else begin
            ovf_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge pll_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ck_q         <= 1'b0;
         ck_prev_q    <= 1'b0;
         d_q          <= 1'b0;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         done_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         trunc_err_q  <= 1'b0;
         gap_err_q    <= 1'b0;
         ovf_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ck_q         <= ck_d;
         ck_prev_q    <= ck_prev_d;
         d_q          <= d_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         done_q       <= done_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         trunc_err_q  <= trunc_err_d;
         gap_err_q    <= gap_err_d;
         ovf_err_q    <= ovf_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = (state_q == RECV);
   assign trunc_err  = trunc_err_q;
   assign gap_err    = gap_err_q;
   assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_sideband_rx_deserializer.sv
// Directed bench: drives sideband packets at 2 pll_clk per UI and checks
// delivered words and error pulse counts against hand-computed values.
module tb_sideband_rx_deserializer;

   logic        pll_clk = 1'b0;
   logic        rst = 1'b1;
   logic        RXCKSB = 1'b0;
   logic        RXDATASB = 1'b0;
   logic [63:0] data_out;
   logic        data_valid;
   logic        data_ready = 1'b0;
   logic        busy, trunc_err, gap_err, ovf_err;

   int n_checks = 0;
   int n_errors = 0;

   // monitor-owned counters
   int          n_vld = 0, n_gap = 0, n_trunc = 0, n_ovf = 0;
   logic [63:0] got[$];

   // snapshots taken by the main process
   int s_vld, s_gap, s_trunc, s_ovf, s_got;

   sideband_rx_deserializer #(.DATA_W(64), .GAP_MIN_CYC(64), .EDGE_TIMEOUT(4)) dut (
      .pll_clk    (pll_clk),
      .rst        (rst),
      .RXCKSB     (RXCKSB),
      .RXDATASB   (RXDATASB),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .trunc_err  (trunc_err),
      .gap_err    (gap_err),
      .ovf_err    (ovf_err)
   );

   always #5 pll_clk = ~pll_clk;

   always begin
      @(negedge pll_clk);
      #1;
      if (data_valid && data_ready) got.push_back(data_out);
      if (data_valid) n_vld++;
      if (gap_err)    n_gap++;
      if (trunc_err)  n_trunc++;
      if (ovf_err)    n_ovf++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_vld = n_vld; s_gap = n_gap; s_trunc = n_trunc; s_ovf = n_ovf; s_got = got.size();
   endtask

   task automatic drive_bit(input logic b);
      @(negedge pll_clk);
      RXCKSB = 1'b1; RXDATASB = b;
      @(negedge pll_clk);
      RXCKSB = 1'b0;
   endtask

   task automatic send(input logic [63:0] v, input int nbits);
      for (int i = 0; i < nbits; i++) drive_bit(v[i]);
   endtask

   task automatic idle_ui(input int n);
      repeat (2 * n) @(negedge pll_clk);
   endtask

   function automatic logic [63:0] got_at(input int idx);
      return (idx < got.size()) ? got[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   initial begin
      repeat (3) @(negedge pll_clk);
      rst = 1'b0;
      #1;
      check("rst_data_out", data_out, 64'h0);
      check("rst_valid", 64'(data_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_errs", 64'({trunc_err, gap_err, ovf_err}), 64'h0);

      // single packet
      data_ready = 1'b1;
      snap();
      send(64'hA5A5A5A5A5A5A5A5, 64);
      idle_ui(40);
      check("p1_count", 64'(got.size() - s_got), 64'd1);
      check("p1_data", got_at(s_got), 64'hA5A5A5A5A5A5A5A5);
      check("p1_valid_cycles", 64'(n_vld - s_vld), 64'd1);
      check("p1_errs", 64'((n_gap - s_gap) + (n_trunc - s_trunc) + (n_ovf - s_ovf)), 64'd0);

      // legal 32 UI gap
      snap();
      send(64'hA5A5A5A5A5A5A5A5, 64);
      idle_ui(32);
      send(64'hB4B4B4B4B4B4B4B4, 64);
      idle_ui(40);
      check("gap_ok_count", 64'(got.size() - s_got), 64'd2);
      check("gap_ok_first", got_at(s_got), 64'hA5A5A5A5A5A5A5A5);
      check("gap_ok_second", got_at(s_got + 1), 64'hB4B4B4B4B4B4B4B4);
      check("gap_ok_gap_err", 64'(n_gap - s_gap), 64'd0);

      // short 10 UI gap
      snap();
      send(64'hB4B4B4B4B4B4B4B4, 64);
      idle_ui(10);
      send(64'h0, 64);
      idle_ui(40);
      check("gap_short_gap_err", 64'(n_gap - s_gap), 64'd1);
      check("gap_short_count", 64'(got.size() - s_got), 64'd2);
      check("gap_short_second", got_at(s_got + 1), 64'h0);

      // truncated packet
      snap();
      send(64'hFFFFFFFFFFFFFFFF, 40);
      #1;
      check("trunc_busy", 64'(busy), 64'd1);
      idle_ui(20);
      check("trunc_pulse", 64'(n_trunc - s_trunc), 64'd1);
      check("trunc_no_valid", 64'(n_vld - s_vld), 64'd0);
      check("trunc_busy_after", 64'(busy), 64'd0);
      send(64'h0123456789ABCDEF, 64);
      idle_ui(40);
      check("trunc_next_data", got_at(s_got), 64'h0123456789ABCDEF);

      // overflow with data_ready held low
      data_ready = 1'b0;
      snap();
      send(64'h1, 64);
      idle_ui(40);
      send(64'h2, 64);
      idle_ui(40);
      check("ovf_pulse", 64'(n_ovf - s_ovf), 64'd1);
      check("ovf_hold_data", data_out, 64'h1);
      check("ovf_hold_valid", 64'(data_valid), 64'd1);
      data_ready = 1'b1;
      repeat (2) @(negedge pll_clk);
      #1;
      check("ovf_drain_valid", 64'(data_valid), 64'd0);
      check("ovf_drain_count", 64'(got.size() - s_got), 64'd1);
      check("ovf_drain_data", got_at(s_got), 64'h1);

      // reset mid-packet
      snap();
      send(64'hFFFFFFFFFFFFFFFF, 30);
      rst = 1'b1;
      repeat (2) @(negedge pll_clk);
      rst = 1'b0;
      #1;
      check("mrst_data_out", data_out, 64'h0);
      check("mrst_outs", 64'({data_valid, busy, trunc_err, gap_err, ovf_err}), 64'h0);
      idle_ui(10);
      check("mrst_no_errs", 64'((n_gap - s_gap) + (n_trunc - s_trunc) + (n_ovf - s_ovf)), 64'd0);
      send(64'hFFFF0000FFFF0000, 64);
      idle_ui(40);
      check("mrst_next_count", 64'(got.size() - s_got), 64'd1);
      check("mrst_next_data", got_at(s_got), 64'hFFFF0000FFFF0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
